// File: rtl/csa_ctrl_pkg.sv
// Shared definitions for the multicycle carry-select add controller.
// Holds the FSM encoding and helpers that size the chunk index from WIDTH/CHUNK.
package csa_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk_slice.sv
// Combinational CHUNK-bit carry-select slice: both carry-in cases are
// precomputed and the registered carry picks one.
module csa_chunk_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_sel_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);

    logic [CHUNK:0] res0;
    logic [CHUNK:0] res1;

    assign res0 = {1'b0, a_i} + {1'b0, b_i};
    assign res1 = {1'b0, a_i} + {1'b0, b_i} + (CHUNK + 1)'(1);

    assign s_o = c_sel_i ? res1[CHUNK-1:0] : res0[CHUNK-1:0];
    assign c_o = c_sel_i ? res1[CHUNK]     : res0[CHUNK];

endmodule

// File: rtl/csa_multicycle_add_ctrl.sv
// Sequencer adding WIDTH-bit operands one CHUNK per cycle on a shared slice.
// Define CSA_CTRL_SUB_EN to add the sub port (a - b via inverted b, carry-in 1).
module csa_multicycle_add_ctrl
    import csa_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CSA_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NCH   = nch(WIDTH, CHUNK);
    localparam int IDX_W = idx_width(NCH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 2 || CHUNK > 16) begin : g_param_check
        $error("csa_multicycle_add_ctrl: WIDTH must be a multiple of CHUNK, CHUNK in 2..16");
    end

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             c_out_q,     c_out_d;
    logic             out_valid_q, out_valid_d;

    logic             sub_op;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

`ifdef CSA_CTRL_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    csa_chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .a_i     (a_q[idx_q*CHUNK +: CHUNK]),
        .b_i     (b_q[idx_q*CHUNK +: CHUNK]),
        .c_sel_i (carry_q),
        .s_o     (slice_sum),
        .c_o     (slice_cout)
    );

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub_op ? ~b : b;
                    carry_d = sub_op ? 1'b1 : c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    c_out_d     = slice_cout;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_csa_multicycle_add_ctrl.sv
// Scoreboard bench for csa_multicycle_add_ctrl (WIDTH=32, CHUNK=8).
// The driver pushes hand-computed results; a monitor pops them on each output handshake.
module tb_csa_multicycle_add_ctrl;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             sub_s = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    result_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    always #5 clk = ~clk;

    csa_multicycle_add_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef CSA_CTRL_SUB_EN
        .sub       (sub_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: one compare per output handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got sum=0x%0h c_out=%0b, expected no output", sum, c_out);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("result_sum", 64'(sum), 64'(e.sum));
                check("result_c_out", 64'(c_out), 64'(e.c_out));
            end
        end
    end

    // Issue one operation; returns once the accept edge has passed.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        a = av; b = bv; c_in = cv; sub_s = sv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '1; b = '1; c_in = ~cv; sub_s = ~sv;
    endtask

    // Counts edges from accept to out_valid and checks the latency.
    task automatic wait_result(input string name);
        int edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 40);
        check(name, 64'(edges), 64'(NCH));
    endtask

    task automatic do_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv,
                         input logic [WIDTH-1:0] es, input logic ec);
        exp_q.push_back('{sum: es, c_out: ec});
        issue(av, bv, cv, sv);
        wait_result(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, checked while reset is still asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        rst_n = 1'b1;

        // Carry ripples through every chunk.
        do_op("lat_all_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        do_op("lat_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0);
        do_op("lat_chunk_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0);
        do_op("lat_msb_wrap", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

        // Backpressure in DONE with in_valid pulsed: everything must hold.
        out_ready = 1'b0;
        exp_q.push_back('{sum: 32'h0000_0030, c_out: 1'b0});
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        wait_result("lat_hold");
        a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; c_in = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_sum", 64'(sum), 64'h30);
            check("hold_c_out", 64'(c_out), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_hold_busy", 64'(busy), 64'd0);
        check("post_hold_out_valid", 64'(out_valid), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("no_capture_while_busy", 64'(out_valid | busy), 64'd0);

        // Reset while RUN is at idx=2: abort with no result presented.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_op("lat_after_abort", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1);

`ifdef CSA_CTRL_SUB_EN
        do_op("lat_sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        do_op("lat_sub_noborrow", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
